// File: rtl/fir_l2_output_serializer.sv
// Output stage of the 2-parallel FIR: rounds/saturates each sample pair to audio width,
// buffers pairs and streams them out one sample per handshake, earlier sample first.
//
// state     | meaning
// PH_FIRST  | head pair's sample 1 is presented on data_out
// PH_SECOND | head pair's sample 2 is presented; accepting it pops the pair
module fir_l2_output_serializer #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 23,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [IN_WIDTH-1:0]  data_in_1,
   input  logic signed [IN_WIDTH-1:0]  data_in_2,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_WIDTH-1:0] data_out,
   output logic [CNT_WIDTH-1:0]        sat_count,
   input  logic                        sat_clear
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic signed [IN_WIDTH:0] RND  = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT-1);
   localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [IN_WIDTH:0] MINV = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic {
      PH_FIRST  = 1'b0,
      PH_SECOND = 1'b1
   } phase_t;

   phase_t                  phase_q, phase_d;
   logic [ADDR_W-1:0]       wr_ptr, rd_ptr;
   logic [ADDR_W:0]         occ;
   logic                    ready_en;
   logic [2*OUT_WIDTH-1:0]  buf_mem [DEPTH];
   logic [2*OUT_WIDTH-1:0]  head;
   logic                    push, pop;
   logic signed [OUT_WIDTH-1:0] s1, s2;
   logic                    sat1, sat2;
   logic [1:0]              sat_inc;
   logic [CNT_WIDTH-1:0]    sat_base, sat_next;
   logic [CNT_WIDTH:0]      sat_sum;

   // Returns {saturated, sample}; the extra bit on t keeps the rounding add from overflowing.
   function automatic logic [OUT_WIDTH:0] conv(input logic signed [IN_WIDTH-1:0] x);
      logic signed [IN_WIDTH:0] t;
      logic signed [IN_WIDTH:0] y;
      t = $signed({x[IN_WIDTH-1], x}) + RND;
      y = t >>> SHIFT;
      if (y > MAXV)
         conv = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (y < MINV)
         conv = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
         conv = {1'b0, y[OUT_WIDTH-1:0]};
   endfunction

   always_comb begin
      {sat1, s1} = conv(data_in_1);
      {sat2, s2} = conv(data_in_2);
   end

   // ready_en holds in_ready low during reset and for no longer than that
   assign in_ready  = ready_en && (occ < DEPTH_C);
   assign out_valid = (occ != '0);
   assign push      = in_valid && in_ready;
   assign head      = buf_mem[rd_ptr];

   always_comb begin
      phase_d  = phase_q;
      pop      = 1'b0;
      data_out = '0;
      if (out_valid)
         data_out = (phase_q == PH_FIRST) ? head[OUT_WIDTH-1:0] : head[2*OUT_WIDTH-1:OUT_WIDTH];
      if (out_valid && out_ready) begin
         case (phase_q)
            PH_FIRST:  phase_d = PH_SECOND;
            PH_SECOND: begin
               phase_d = PH_FIRST;
               pop     = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      sat_inc  = push ? ({1'b0, sat1} + {1'b0, sat2}) : 2'b00;
      sat_base = sat_clear ? '0 : sat_count;
      sat_sum  = {1'b0, sat_base} + {{(CNT_WIDTH-1){1'b0}}, sat_inc};
      sat_next = sat_sum[CNT_WIDTH] ? '1 : sat_sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q   <= PH_FIRST;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         ready_en  <= 1'b0;
         sat_count <= '0;
      end else begin
         ready_en  <= 1'b1;
         phase_q   <= phase_d;
         sat_count <= sat_next;
         if (push)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + ADDR_W'(1);
         occ <= occ + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push)
         buf_mem[wr_ptr] <= {s2, s1};
   end

endmodule

// File: tb/tb_fir_l2_output_serializer.sv
// Directed bench for fir_l2_output_serializer: vector table for conversion, then
// back-pressure, sine streaming against a scoreboard, and mid-stream reset.
module tb_fir_l2_output_serializer;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [63:0] data_in_1;
   logic signed [63:0] data_in_2;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] data_out;
   logic [15:0]        sat_count;
   logic               sat_clear;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fir_l2_output_serializer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in_1 (data_in_1),
      .data_in_2 (data_in_2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .sat_count (sat_count),
      .sat_clear (sat_clear)
   );

   typedef struct {
      longint d1;
      longint d2;
      bit     clr;
      int     e1;
      int     e2;
      int     esat;
   } vec_t;

   localparam longint ONE = 64'sd8388608;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model(input longint x, output bit s);
      longint y;
      y = (x + 64'sd4194304) >>> 23;
      s = 1'b0;
      if (y > 32767) begin
         y = 32767;
         s = 1'b1;
      end else if (y < -32768) begin
         y = -32768;
         s = 1'b1;
      end
      return int'(y);
   endfunction

   vec_t   vecs [7];
   longint q[$];
   int     exp_bp [8];

   initial begin
      int     k, cyc, msat, exp_sat;
      bit     sa, sb, acc;
      longint x1, x2;
      real    ph;

      vecs[0] = '{64'sd8388608,       64'sd12582912,       1'b0, 1,      2,      0};
      vecs[1] = '{-64'sd12582912,     -64'sd4194304,       1'b0, -1,     0,      0};
      vecs[2] = '{64'sd20971520,      -64'sd8388608,       1'b0, 3,      -1,     0};
      vecs[3] = '{64'sd1099511627776, -64'sd1099511627776, 1'b0, 32767,  -32768, 2};
      vecs[4] = '{64'sd274873712639,  64'sd274873712640,   1'b0, 32767,  32767,  3};
      vecs[5] = '{-64'sd274882101248, -64'sd274882101249,  1'b0, -32768, -32768, 4};
      vecs[6] = '{64'sd1099511627776, 64'sd2199023255552,  1'b1, 32767,  32767,  2};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sat_clear = 1'b0;
      data_in_1 = '0;
      data_in_2 = '0;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_sat_count", sat_count, 0);
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      // Conversion table: each pair into an empty buffer with out_ready held high
      for (int i = 0; i < 7; i++) begin
         chk("vec_in_ready", in_ready, 1);
         in_valid  = 1'b1;
         data_in_1 = vecs[i].d1;
         data_in_2 = vecs[i].d2;
         sat_clear = vecs[i].clr;
         step();
         in_valid  = 1'b0;
         sat_clear = 1'b0;
         chk("vec_valid_s1", out_valid, 1);
         chk("vec_sample1", data_out, vecs[i].e1);
         chk("vec_sat_count", sat_count, vecs[i].esat);
         step();
         chk("vec_valid_s2", out_valid, 1);
         chk("vec_sample2", data_out, vecs[i].e2);
         step();
         chk("vec_drained", out_valid, 0);
      end

      // Back-pressure: fill, offer a refused saturating pair, then drain
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_in_ready_fill", in_ready, 1);
         in_valid  = 1'b1;
         data_in_1 = longint'(10*i + 1) * ONE;
         data_in_2 = longint'(10*i + 2) * ONE;
         exp_bp[2*i]   = 10*i + 1;
         exp_bp[2*i+1] = 10*i + 2;
         step();
      end
      chk("bp_full_in_ready", in_ready, 0);
      data_in_1 = 64'sd1099511627776;
      data_in_2 = 64'sd1099511627776;
      step();
      step();
      in_valid = 1'b0;
      chk("bp_refused_not_counted", sat_count, 2);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", data_out, 1);
      out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         chk("bp_drain_in_ready", in_ready, (j >= 2) ? 1 : 0);
         chk("bp_drain_valid", out_valid, 1);
         chk("bp_drain_data", data_out, exp_bp[j]);
         step();
      end
      chk("bp_empty", out_valid, 0);

      // Streaming from a sine source slightly above full scale
      k    = 0;
      cyc  = 0;
      msat = 0;
      ph   = 0.0;
      x1 = longint'($sin(6.283185307 * (2.0*k) / 37.0) * 1.2 * 274877906944.0);
      x2 = longint'($sin(6.283185307 * (2.0*k + 1.0) / 37.0) * 1.2 * 274877906944.0);
      data_in_1 = x1;
      data_in_2 = x2;
      in_valid  = 1'b1;
      while ((k < 200 || q.size() > 0) && cyc < 2000) begin
         acc = 1'b0;
         if (in_valid && in_ready) begin
            q.push_back(longint'(model(x1, sa)));
            q.push_back(longint'(model(x2, sb)));
            msat += int'(sa) + int'(sb);
            acc = 1'b1;
         end
         if (out_valid) begin
            if (q.size() == 0)
               chk("stream_unexpected_sample", 1, 0);
            else
               chk("stream_sample", data_out, q.pop_front());
         end
         step();
         cyc++;
         if (acc) begin
            k++;
            if (k < 200) begin
               ph = 2.0 * k;
               x1 = longint'($sin(6.283185307 * ph / 37.0) * 1.2 * 274877906944.0);
               x2 = longint'($sin(6.283185307 * (ph + 1.0) / 37.0) * 1.2 * 274877906944.0);
               data_in_1 = x1;
               data_in_2 = x2;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("stream_pairs_accepted", k, 200);
      chk("stream_queue_empty", q.size(), 0);
      exp_sat = (2 + msat > 65535) ? 65535 : 2 + msat;
      chk("stream_sat_count", sat_count, exp_sat);
      chk("stream_idle", out_valid, 0);

      // Reset with 3 pairs buffered and the head half-sent
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'b1;
         data_in_1 = (i == 0) ? 64'sd1099511627776 : longint'(20 + i) * ONE;
         data_in_2 = longint'(7 + 20*i) * ONE;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("mid_phase_sample2", data_out, 7);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sat_count", sat_count, 0);
      chk("mid_rst_data_out", data_out, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      #99;
      reset_n = 1'b1;
      step();
      step();
      chk("mid_after_rst_valid", out_valid, 0);
      chk("mid_after_rst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      data_in_1 = 5 * ONE;
      data_in_2 = 6 * ONE;
      step();
      in_valid = 1'b0;
      chk("mid_new_sample1", data_out, 5);
      step();
      chk("mid_new_sample2", data_out, 6);
      step();
      chk("mid_new_drained", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_l2_output_serializer.md
Name: fir_l2_output_serializer

Overview:
- Downstream stage of the 2-parallel (L=2) FIR filter.
- Accepts each pair of wide filter outputs (data_out_1 is the earlier sample, data_out_2 the later), rounds and saturates each to audio width, and buffers the pairs.
- Emits them as a single ordered sample stream on a valid/ready interface.
- Counts saturation events for monitoring.

Parameters:
- IN_WIDTH, 64, width of each filter output sample (signed).
- OUT_WIDTH, 16, width of serialized output sample (signed).
- SHIFT, 23, right-shift applied before rounding (Q23 taps); legal range 1..IN_WIDTH-OUT_WIDTH.
- DEPTH, 4, pair-buffer depth in sample pairs (power of 2, ≥2).
- CNT_WIDTH, 16, width of saturation counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pair on data_in_1/data_in_2 is valid.
- in_ready  output  1  block can accept a pair this cycle.
- data_in_1  input  IN_WIDTH  signed, earlier sample of pair.
- data_in_2  input  IN_WIDTH  signed, later sample of pair.
- out_valid  output  1  data_out holds a valid sample.
- out_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  OUT_WIDTH  signed serialized sample.
- sat_count  output  CNT_WIDTH  number of saturated samples since reset/clear.
- sat_clear  input  1  synchronous clear of sat_count.

Behaviour:
- Reset (reset_n low, asynchronous): buffer empty, read/write pointers 0, phase 0, out_valid 0, data_out 0, sat_count 0. in_ready is 0 while reset_n is low and 1 from the first cycle after release. Reset mid-stream discards all buffered pairs and any half-sent pair.
- Conversion, applied to each input sample independently, combinationally before the buffer write:
  - t = x + 2^(SHIFT-1), computed at IN_WIDTH+1 bits.
  - y = t >>> SHIFT (arithmetic), giving round-half-up: +1.5→2, -1.5→-1, +2.5→3.
  - If y > 2^(OUT_WIDTH-1)-1, output 32767 and flag saturated. If y < -2^(OUT_WIDTH-1), output -32768 and flag saturated.
- Input handshake:
  - Pair accepted on a rising edge when in_valid && in_ready.
  - in_ready = (occupancy < DEPTH), derived from registered state only; no combinational path from out_ready.
  - Full buffer with a same-cycle pop: in_ready stays 0 that cycle.
  - Converted pair written at the write pointer; pointer wraps modulo DEPTH.
- Output sequencing:
  - out_valid = (occupancy > 0). data_out is the head pair's sample 1 when phase=0, sample 2 when phase=1.
  - On out_valid && out_ready: phase=0 → phase becomes 1. phase=1 → phase becomes 0, the pair is popped, and the read pointer wraps modulo DEPTH.
  - data_out and out_valid are held stable while out_valid && !out_ready.
  - Simultaneous push and pop (non-full): occupancy unchanged, both operations take effect.
- Latency: pair accepted at edge N into an empty buffer → out_valid=1 with sample 1 after edge N; sample 2 follows one cycle later if out_ready=1.
- Throughput: steady state is one pair per 2 cycles; in_ready de-asserts when full, and upstream must stall.
- Saturation counter:
  - On each accepted pair, sat_count increases by the number of saturated samples in that pair (0, 1 or 2), saturating at 2^CNT_WIDTH-1 with no wrap.
  - sat_clear zeroes the counter and then adds that cycle's increment, so the result equals the same-cycle increment.
  - Samples offered while in_ready=0 are never counted.

Test Plan:
- Reset release, then one pair: data_in_1=8388608, data_in_2=12582912 → out_valid next cycle; data_out=1 then 2; sat_count=0.
- Rounding and negatives: pair (-12582912, -4194304) → outputs -1 then 0. Pair (20971520, -8388608) → outputs 3 then -1.
- Saturation: pair (2^40, -2^40) → outputs 32767 then -32768; sat_count=2. Assert sat_clear in the same cycle as the next saturating pair → sat_count=2 (equal to the increment).
- Back-pressure: hold out_ready=0 and push 4 pairs.
  - Expect in_ready=0 after the 4th; a 5th offered pair is not accepted and not counted.
  - data_out stays at the first pair's sample 1.
  - Then out_ready=1 → 8 samples emitted in push order; in_ready returns to 1 one cycle after the first pop.
- Streaming: in_valid=1 for 200 pairs from the sine source with out_ready=1 → output equals the reference model's sample-interleaved stream, with no drops or duplicates across pointer wrap.
- Reset mid-operation: 3 pairs buffered and phase=1, pulse reset_n low 100 ns → out_valid=0, sat_count=0 immediately. After release, a new pair emits its sample 1 first.
